alu_design: RTL and testbench

//  Parameterised, registered ALU. Performs arithmetic ops (MODE=1) and logical ops (MODE=0) on OPA/OPB.

---
 rtl/alu_design.sv | 181 ++++++++++++++++++
 tb/tb_alu_design.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_design.sv
// Registered ALU with arithmetic/logical modes, operand validity checking and a
// two-stage multiply path that stalls with the clock enable.
module alu_design #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [1:0]      INP_VALID,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    input  logic [DW-1:0]   OPA,
    input  logic [DW-1:0]   OPB,
    input  logic            CIN,
    output logic [2*DW-1:0] RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            L,
    output logic            E,
    output logic            ERR
);

    localparam int SW = $clog2(DW);
    localparam logic [DW:0] ONE = (DW+1)'(1);

    int unsigned     cmd_i;
    logic [DW:0]     ext_a, ext_b, ext_c;
    logic [DW:0]     sum, diff;
    logic [2*DW-1:0] rot2;
    logic [DW-1:0]   log_res;
    logic            need_a, need_b, illegal, add_op, sub_op, is_mul, rot_err, op_ok;
    logic [DW:0]     mul_a_nxt, mul_b_nxt;
    logic [2*DW-1:0] nxt_res;
    logic            nxt_cout, nxt_oflow, nxt_g, nxt_l, nxt_e, nxt_err;

    logic            mul_pend;
    logic [DW:0]     mul_a, mul_b;

    assign cmd_i = 32'(CMD);
    assign ext_a = {1'b0, OPA};
    assign ext_b = {1'b0, OPB};
    assign ext_c = {{DW{1'b0}}, CIN};

    always_comb begin
        need_a    = 1'b0;
        need_b    = 1'b0;
        illegal   = 1'b0;
        add_op    = 1'b0;
        sub_op    = 1'b0;
        is_mul    = 1'b0;
        rot_err   = 1'b0;
        sum       = '0;
        diff      = '0;
        rot2      = '0;
        log_res   = '0;
        mul_a_nxt = '0;
        mul_b_nxt = '0;
        nxt_res   = '0;
        nxt_cout  = 1'b0;
        nxt_oflow = 1'b0;
        nxt_g     = 1'b0;
        nxt_l     = 1'b0;
        nxt_e     = 1'b0;
        nxt_err   = 1'b0;
        if (MODE) begin
            case (cmd_i)
                0:  begin need_a = 1'b1; need_b = 1'b1; add_op = 1'b1; sum = ext_a + ext_b; end
                1:  begin need_a = 1'b1; need_b = 1'b1; sub_op = 1'b1; diff = ext_a - ext_b; end
                2:  begin need_a = 1'b1; need_b = 1'b1; add_op = 1'b1; sum = ext_a + ext_b + ext_c; end
                3:  begin need_a = 1'b1; need_b = 1'b1; sub_op = 1'b1; diff = ext_a - ext_b - ext_c; end
                4:  begin need_a = 1'b1; add_op = 1'b1; sum = ext_a + ONE; end
                5:  begin need_a = 1'b1; sub_op = 1'b1; diff = ext_a - ONE; end
                6:  begin need_b = 1'b1; add_op = 1'b1; sum = ext_b + ONE; end
                7:  begin need_b = 1'b1; sub_op = 1'b1; diff = ext_b - ONE; end
                8:  begin
                    need_a = 1'b1; need_b = 1'b1;
                    nxt_g  = (OPA > OPB);
                    nxt_l  = (OPA < OPB);
                    nxt_e  = (OPA == OPB);
                end
                9:  begin need_a = 1'b1; need_b = 1'b1; is_mul = 1'b1; mul_a_nxt = ext_a + ONE; mul_b_nxt = ext_b + ONE; end
                10: begin need_a = 1'b1; need_b = 1'b1; is_mul = 1'b1; mul_a_nxt = {1'b0, OPA[DW-2:0], 1'b0}; mul_b_nxt = ext_b; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (cmd_i)
                0:  begin need_a = 1'b1; need_b = 1'b1; log_res = OPA & OPB; end
                1:  begin need_a = 1'b1; need_b = 1'b1; log_res = ~(OPA & OPB); end
                2:  begin need_a = 1'b1; need_b = 1'b1; log_res = OPA | OPB; end
                3:  begin need_a = 1'b1; need_b = 1'b1; log_res = ~(OPA | OPB); end
                4:  begin need_a = 1'b1; need_b = 1'b1; log_res = OPA ^ OPB; end
                5:  begin need_a = 1'b1; need_b = 1'b1; log_res = ~(OPA ^ OPB); end
                6:  begin need_a = 1'b1; log_res = ~OPA; end
                7:  begin need_b = 1'b1; log_res = ~OPB; end
                8:  begin need_a = 1'b1; log_res = OPA >> 1; end
                9:  begin need_a = 1'b1; log_res = OPA << 1; end
                10: begin need_b = 1'b1; log_res = OPB >> 1; end
                11: begin need_b = 1'b1; log_res = OPB << 1; end
                // Rotation by shifting a doubled copy; the wrapped bits land in the kept half.
                12: begin
                    need_a = 1'b1; need_b = 1'b1;
                    rot2    = {OPA, OPA} << OPB[SW-1:0];
                    log_res = rot2[2*DW-1:DW];
                    rot_err = |OPB[DW-1:SW];
                end
                13: begin
                    need_a = 1'b1; need_b = 1'b1;
                    rot2    = {OPA, OPA} >> OPB[SW-1:0];
                    log_res = rot2[DW-1:0];
                    rot_err = |OPB[DW-1:SW];
                end
                default: illegal = 1'b1;
            endcase
            nxt_res = {{DW{1'b0}}, log_res};
        end
        if (add_op) begin
            nxt_res  = {{(DW-1){1'b0}}, sum};
            nxt_cout = sum[DW];
        end
        if (sub_op) begin
            nxt_res   = {{DW{1'b0}}, diff[DW-1:0]};
            nxt_oflow = diff[DW];
        end
        op_ok   = !illegal && (!need_a || INP_VALID[0]) && (!need_b || INP_VALID[1]);
        nxt_err = rot_err;
        if (!op_ok) begin
            nxt_res   = '0;
            nxt_cout  = 1'b0;
            nxt_oflow = 1'b0;
            nxt_g     = 1'b0;
            nxt_l     = 1'b0;
            nxt_e     = 1'b0;
            nxt_err   = 1'b1;
            is_mul    = 1'b0;
        end
    end

    // A pending multiply owns the next enabled edge; any command offered then is dropped.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            RES      <= '0;
            COUT     <= 1'b0;
            OFLOW    <= 1'b0;
            G        <= 1'b0;
            L        <= 1'b0;
            E        <= 1'b0;
            ERR      <= 1'b0;
            mul_pend <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else if (CE) begin
            if (mul_pend) begin
                RES      <= (2*DW)'(mul_a) * (2*DW)'(mul_b);
                COUT     <= 1'b0;
                OFLOW    <= 1'b0;
                G        <= 1'b0;
                L        <= 1'b0;
                E        <= 1'b0;
                ERR      <= 1'b0;
                mul_pend <= 1'b0;
            end else if (INP_VALID != 2'b00) begin
                if (is_mul) begin
                    mul_pend <= 1'b1;
                    mul_a    <= mul_a_nxt;
                    mul_b    <= mul_b_nxt;
                end else begin
                    RES   <= nxt_res;
                    COUT  <= nxt_cout;
                    OFLOW <= nxt_oflow;
                    G     <= nxt_g;
                    L     <= nxt_l;
                    E     <= nxt_e;
                    ERR   <= nxt_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_design.sv
// Vector-table bench for alu_design with a scoreboard queue of expected results
// plus hand-written hold, stall, dropped-issue and reset-mid-multiply sequences.
module tb_alu_design;

    logic        CLK;
    logic        RST;
    logic        CE;
    logic [1:0]  INP_VALID;
    logic        MODE;
    logic [3:0]  CMD;
    logic [7:0]  OPA, OPB;
    logic        CIN;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, L, E, ERR;

    // flags packed as {COUT, OFLOW, G, L, E, ERR}
    typedef struct {
        logic [1:0]  iv;
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic        cin;
        logic [15:0] res;
        logic [5:0]  flags;
        logic        mul;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [5:0]  flags;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks;
    int   failures;

    alu_design #(.DW(8), .CW(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES),
        .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic [1:0] iv, input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        INP_VALID = iv;
        MODE      = mode;
        CMD       = cmd;
        OPA       = a;
        OPB       = b;
        CIN       = cin;
    endtask

    task automatic pushExp(input logic [15:0] res, input logic [5:0] flags, input string nm);
        exp_t x;
        x.res   = res;
        x.flags = flags;
        x.name  = nm;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t v, input string nm);
        @(negedge CLK);
        drive(v.iv, v.mode, v.cmd, v.opa, v.opb, v.cin);
        pushExp(v.res, v.flags, nm);
        @(posedge CLK);
        if (v.mul) begin
            @(negedge CLK);
            INP_VALID = 2'b00;
            @(posedge CLK);
        end
        #1;
    endtask

    task automatic checkOutput();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: no expected entry queued, RES=%h", RES);
        end else begin
            x = sb.pop_front();
            if (RES !== x.res || {COUT, OFLOW, G, L, E, ERR} !== x.flags) begin
                failures++;
                $display("[TB] FAIL %s: got RES=%h flags=%b, expected RES=%h flags=%b",
                         x.name, RES, {COUT, OFLOW, G, L, E, ERR}, x.res, x.flags);
            end
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //             iv     mode  cmd    opa    opb    cin   res       flags      mul
        vecs.push_back('{2'b11, 1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 16'h0100, 6'b100000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd1,  8'h03, 8'h05, 1'b0, 16'h00FE, 6'b010000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd2,  8'h10, 8'h20, 1'b1, 16'h0031, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd3,  8'h10, 8'h05, 1'b1, 16'h000A, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd3,  8'h05, 8'h05, 1'b1, 16'h00FF, 6'b010000, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 4'd4,  8'hFF, 8'h00, 1'b0, 16'h0100, 6'b100000, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 4'd5,  8'h00, 8'h00, 1'b0, 16'h00FF, 6'b010000, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 4'd6,  8'h00, 8'h07, 1'b0, 16'h0008, 6'b000000, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 4'd7,  8'h00, 8'h80, 1'b0, 16'h007F, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd8,  8'h42, 8'h42, 1'b0, 16'h0000, 6'b000010, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd8,  8'h09, 8'h04, 1'b0, 16'h0000, 6'b001000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd8,  8'h03, 8'hC8, 1'b0, 16'h0000, 6'b000100, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 4'd9,  8'h02, 8'h03, 1'b0, 16'h000C, 6'b000000, 1'b1});
        vecs.push_back('{2'b11, 1'b1, 4'd10, 8'h81, 8'h02, 1'b0, 16'h0004, 6'b000000, 1'b1});
        vecs.push_back('{2'b11, 1'b1, 4'd9,  8'hFF, 8'hFF, 1'b0, 16'h0000, 6'b000000, 1'b1});
        vecs.push_back('{2'b11, 1'b1, 4'd9,  8'hFE, 8'h0F, 1'b0, 16'h0FF0, 6'b000000, 1'b1});
        vecs.push_back('{2'b11, 1'b1, 4'd11, 8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 4'd0,  8'h01, 8'h01, 1'b0, 16'h0000, 6'b000001, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 16'h0030, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd1,  8'hF0, 8'h3C, 1'b0, 16'h00CF, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd2,  8'hF0, 8'h3C, 1'b0, 16'h00FC, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd3,  8'hF0, 8'h3C, 1'b0, 16'h0003, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd4,  8'hF0, 8'h3C, 1'b0, 16'h00CC, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd5,  8'hF0, 8'h3C, 1'b0, 16'h0033, 6'b000000, 1'b0});
        vecs.push_back('{2'b01, 1'b0, 4'd6,  8'h5A, 8'h00, 1'b0, 16'h00A5, 6'b000000, 1'b0});
        vecs.push_back('{2'b10, 1'b0, 4'd7,  8'h00, 8'h0F, 1'b0, 16'h00F0, 6'b000000, 1'b0});
        vecs.push_back('{2'b01, 1'b0, 4'd8,  8'h81, 8'h00, 1'b0, 16'h0040, 6'b000000, 1'b0});
        vecs.push_back('{2'b01, 1'b0, 4'd9,  8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000, 1'b0});
        vecs.push_back('{2'b10, 1'b0, 4'd10, 8'h00, 8'h02, 1'b0, 16'h0001, 6'b000000, 1'b0});
        vecs.push_back('{2'b10, 1'b0, 4'd11, 8'h00, 8'hC0, 1'b0, 16'h0080, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 16'h0003, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 16'h00C0, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd13, 8'h81, 8'h07, 1'b0, 16'h0003, 6'b000000, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd12, 8'h81, 8'h10, 1'b0, 16'h0081, 6'b000001, 1'b0});
        vecs.push_back('{2'b10, 1'b0, 4'd6,  8'h5A, 8'h00, 1'b0, 16'h0000, 6'b000001, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 4'd15, 8'h00, 8'h00, 1'b0, 16'h0000, 6'b000001, 1'b0});

        // Reset with CE high and a valid command offered: reset must win.
        RST = 1'b0;
        CE  = 1'b1;
        drive(2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
        pushExp(16'h0000, 6'b000000, "reset");
        clocks(2);
        checkOutput();
        @(negedge CLK);
        RST = 1'b1;
        INP_VALID = 2'b00;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput();
        end

        // INP_VALID=00 holds outputs even with other inputs moving.
        applyStimulus(vecs[0], "add_before_hold");
        checkOutput();
        @(negedge CLK);
        drive(2'b00, 1'b1, 4'd1, 8'h03, 8'h05, 1'b0);
        pushExp(16'h0100, 6'b100000, "iv00_hold");
        clocks(2);
        checkOutput();

        // CE=0 holds outputs while a valid command is offered.
        @(negedge CLK);
        CE = 1'b0;
        drive(2'b11, 1'b1, 4'd1, 8'h03, 8'h05, 1'b0);
        pushExp(16'h0100, 6'b100000, "ce_hold");
        clocks(2);
        checkOutput();

        // Multiply stalled by CE=0 completes once CE returns.
        @(negedge CLK);
        CE = 1'b1;
        drive(2'b11, 1'b1, 4'd9, 8'h02, 8'h03, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        CE = 1'b0;
        INP_VALID = 2'b00;
        pushExp(16'h0100, 6'b100000, "mul_stalled");
        clocks(3);
        checkOutput();
        @(negedge CLK);
        CE = 1'b1;
        pushExp(16'h000C, 6'b000000, "mul_after_stall");
        clocks(1);
        checkOutput();

        // A command in the cycle after a multiply issue is dropped.
        @(negedge CLK);
        drive(2'b11, 1'b1, 4'd10, 8'h81, 8'h02, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        drive(2'b11, 1'b1, 4'd0, 8'h10, 8'h20, 1'b0);
        pushExp(16'h0004, 6'b000000, "mul_vs_next");
        clocks(1);
        checkOutput();
        @(negedge CLK);
        INP_VALID = 2'b00;
        pushExp(16'h0004, 6'b000000, "dropped_issue");
        clocks(1);
        checkOutput();

        // Reset while a multiply is in flight discards the product.
        @(negedge CLK);
        drive(2'b11, 1'b1, 4'd9, 8'h02, 8'h03, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        INP_VALID = 2'b00;
        pushExp(16'h0000, 6'b000000, "reset_mid_mul");
        clocks(1);
        checkOutput();
        @(negedge CLK);
        RST = 1'b1;
        pushExp(16'h0000, 6'b000000, "mul_discarded");
        clocks(2);
        checkOutput();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
